// File: rtl/hilo_mult_seq.sv
// Hi/Lo register pair with a 1-bit-per-cycle shift-add multiplier for the EX stage.
// Multiply: WIDTH CALC cycles + 1 FIX cycle; mthi/mtlo commit on the accept edge.
module hilo_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_rd_req,
  input  logic [4:0]       i_alu_ctl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b01100;
  localparam logic [4:0] OP_MADD  = 5'b11010;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;
  logic [4:0]         r_op;

  logic               w_is_mul;
  logic               w_is_signed;
  logic               w_idle;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [2*WIDTH-1:0] w_p;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_commit;

  assign w_idle      = (r_state == S_IDLE);
  assign w_is_mul    = (i_alu_ctl == OP_MULT) || (i_alu_ctl == OP_MULTU) ||
                       (i_alu_ctl == OP_MADD) || (i_alu_ctl == OP_MSUB);
  assign w_is_signed = (i_alu_ctl != OP_MULTU);

  // Signed ops multiply magnitudes; the sign is reapplied in FIX.
  assign w_a_mag = (w_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag = (w_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  assign w_pp       = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  assign w_prod_nxt = r_mplier[0] ? (r_prod + w_pp) : r_prod;
  assign w_p        = r_sign ? -r_prod : r_prod;
  assign w_hilo     = {r_hi, r_lo};

  always_comb begin
    w_commit = w_p;
    case (r_op)
      OP_MADD: w_commit = w_hilo + w_p;
      OP_MSUB: w_commit = w_hilo - w_p;
      default: w_commit = w_p;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != S_IDLE);
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start && w_is_mul) w_state_nxt = S_CALC;
      S_CALC: if (r_cnt == LAST_CNT) w_state_nxt = S_FIX;
      S_FIX: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_stall = o_busy && (i_start || i_rd_req);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_alu_ctl == OP_MTHI) begin
              r_hi <= i_a;
            end else if (i_alu_ctl == OP_MTLO) begin
              r_lo <= i_a;
            end else if (w_is_mul) begin
              r_mcand  <= w_a_mag;
              r_mplier <= w_b_mag;
              r_sign   <= w_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
              r_op     <= i_alu_ctl;
              r_prod   <= '0;
              r_cnt    <= '0;
            end
          end
        end
        S_CALC: begin
          r_prod   <= w_prod_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi <= w_commit[2*WIDTH-1:WIDTH];
          r_lo <= w_commit[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Scoreboarded bench for hilo_mult_seq: directed vectors, expected Hi:Lo queued at issue.
module tb_hilo_mult_seq;

  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b01100;
  localparam logic [4:0] OP_MADD  = 5'b11010;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_rd_req = 1'b0;
  logic [4:0]  i_alu_ctl = 5'b0;
  logic [31:0] i_a = 32'b0;
  logic [31:0] i_b = 32'b0;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_stall;
  logic        o_done;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  hilo_mult_seq #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_rd_req(i_rd_req),
    .i_alu_ctl(i_alu_ctl), .i_a(i_a), .i_b(i_b), .o_hi(o_hi), .o_lo(o_lo),
    .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the cycle after a Done pulse, Hi:Lo must equal the oldest queued result.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        @(negedge i_clk);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          check("hilo_commit", {o_hi, o_lo}, exp_q.pop_front());
        end
      end
    end
  end

  // Presents an op at a negedge, holds it through any stall, releases after the accept edge.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge i_clk);
    i_start = 1'b1; i_alu_ctl = op; i_a = a; i_b = b;
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd1, 64'd0);
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic mul_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    exp_q.push_back(exp);
    do_op(op, a, b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
    @(negedge i_clk);
  endtask

  initial begin
    int busy_cyc;
    int done_cyc;
    int n;
    logic [31:0] old_hi;

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_hilo", {o_hi, o_lo}, 64'd0);
    check("rst_flags", {61'd0, o_busy, o_stall, o_done}, 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_rd_req = 1'b1;
    #1 check("idle_read_no_stall", {63'd0, o_stall}, 64'd0);
    i_rd_req = 1'b0;

    // mult -3 * 5: busy length and Done pulse count
    mul_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
    busy_cyc = 0; done_cyc = 0; n = 0;
    @(negedge i_clk);
    while (o_busy && n < 200) begin
      busy_cyc++;
      if (o_done) done_cyc++;
      @(negedge i_clk);
      n++;
    end
    check("busy_cycles", 64'(busy_cyc), 64'd33);
    check("done_pulses", 64'(done_cyc), 64'd1);
    @(negedge i_clk);

    mul_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    wait_idle();
    mul_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    wait_idle();

    // madd carry from Lo into Hi
    do_op(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    check("mtlo_busy", {63'd0, o_busy}, 64'd0);
    do_op(OP_MTHI, 32'h00000000, 32'h0);
    @(negedge i_clk);
    check("mthi_mtlo", {o_hi, o_lo}, 64'h00000000_FFFFFFFF);
    mul_op(OP_MADD, 32'd1, 32'd1, 64'h00000001_00000000);
    wait_idle();

    // msub from zero
    do_op(OP_MTLO, 32'h0, 32'h0);
    do_op(OP_MTHI, 32'h0, 32'h0);
    mul_op(OP_MSUB, 32'd2, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
    wait_idle();

    // mfhi while a mult is in flight
    old_hi = o_hi;
    mul_op(OP_MULT, 32'd7, 32'd9, 64'h00000000_0000003F);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rd_req = 1'b1;
    #1 check("rd_stall_rise", {63'd0, o_stall}, 64'd1);
    n = 0;
    while (o_busy && n < 200) begin
      check("rd_stall_held", {63'd0, o_stall}, 64'd1);
      check("hi_held", {32'd0, o_hi}, {32'd0, old_hi});
      @(negedge i_clk);
      n++;
    end
    check("rd_stall_released", {63'd0, o_stall}, 64'd0);
    check("hi_after_commit", {32'd0, o_hi}, 64'd0);
    i_rd_req = 1'b0;

    // mthi while busy lands after the multiply commits
    mul_op(OP_MULT, 32'd2, 32'd3, 64'h00000000_00000006);
    @(negedge i_clk);
    i_start = 1'b1; i_alu_ctl = OP_MTHI; i_a = 32'hAAAA5555;
    #1 check("mthi_stall", {63'd0, o_stall}, 64'd1);
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("mthi_not_early", {32'd0, o_hi}, 64'd0);
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    check("mthi_landed", {o_hi, o_lo}, 64'hAAAA5555_00000006);

    // Asynchronous reset mid-CALC
    do_op(OP_MTLO, 32'h12345678, 32'h0);
    do_op(OP_MTHI, 32'h12345678, 32'h0);
    mul_op(OP_MULT, 32'd5, 32'd5, 64'd25);
    repeat (3) @(negedge i_clk);
    i_rd_req = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_hilo", {o_hi, o_lo}, 64'd0);
    check("arst_flags", {61'd0, o_busy, o_stall, o_done}, 64'd0);
    void'(exp_q.pop_back());
    @(negedge i_clk);
    i_rst_n = 1'b1; i_rd_req = 1'b0;
    exp_q.push_back(64'h00000000_0000000C);
    i_start = 1'b1; i_alu_ctl = OP_MULT; i_a = 32'd3; i_b = 32'd4;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    check("post_rst_accept", {63'd0, o_busy}, 64'd1);
    wait_idle();
    repeat (2) @(negedge i_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
